// File: rtl/bus_pkg.sv
// Shared serial-bus definitions used by the initiator and target ports.
package bus_pkg;

  localparam int BUS_ADDR_W = 16;
  localparam int BUS_DATA_W = 8;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_DATA = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    WDATA,
    WR_REQ,
    RD_REQ,
    RD_WAIT,
    SPLIT,
    RD_OUT,
    ACK
  } target_state_e;

endpackage

// File: rtl/serial_tx.sv
// 8-bit parallel-in serial-out shifter, LSB first; valid stays high for exactly WIDTH bits.
module serial_tx
  import bus_pkg::*;
#(
  parameter int WIDTH = BUS_DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  output logic             data_out,
  output logic             valid
);

  localparam int CNT_W = (WIDTH < 2) ? 1 : $clog2(WIDTH);

  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic             active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg  <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (load) begin
      shreg  <= load_data;
      cnt    <= '0;
      active <= 1'b1;
    end else if (shift && active) begin
      shreg <= shreg >> 1;
      cnt   <= cnt + 1'b1;
      if (cnt == CNT_W'(WIDTH - 1)) active <= 1'b0;
    end
  end

  // Gate the data bit so the line idles low between bursts.
  assign data_out = active & shreg[0];
  assign valid    = active;

endmodule

// File: rtl/target_port.sv
// Serial-bus target endpoint: deserialises address/write data, issues single-beat
// memory accesses and serialises read data back, splitting slow reads.
module target_port
  import bus_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH  = 12,
  parameter bit SPLIT_EN        = 1'b1,
  parameter int SPLIT_THRESHOLD = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      bus_sel,
  input  logic                      bus_data_in,
  input  logic                      bus_data_in_valid,
  input  logic                      bus_mode,
  input  logic                      bus_rw,
  output logic                      bus_data_out,
  output logic                      bus_data_out_valid,
  output logic                      target_ack,
  output logic                      target_split,
  output logic                      split_req,
  input  logic                      split_grant,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [BUS_DATA_W-1:0]     mem_wdata,
  output logic                      mem_wen,
  output logic                      mem_ren,
  input  logic                      mem_ready,
  input  logic [BUS_DATA_W-1:0]     mem_rdata,
  input  logic                      mem_rvalid
);

  localparam int WAIT_W = (SPLIT_THRESHOLD < 2) ? 1 : $clog2(SPLIT_THRESHOLD);

  target_state_e state, state_nxt;

  logic [4:0]                bit_cnt;
  logic [WAIT_W-1:0]         wait_cnt;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  logic [BUS_DATA_W-1:0]     wdata_q;
  logic [BUS_DATA_W-1:0]     rdata_q;
  logic                      have_data;
  logic                      split_q;

  logic                  addr_bit_en;
  logic                  wdata_bit_en;
  logic                  rdata_cap;
  logic                  wait_inc;
  logic                  split_set;
  logic                  tx_load;
  logic [BUS_DATA_W-1:0] tx_load_data;
  logic                  wait_hit;
  logic [3:0]            addr_idx;

  assign wait_hit = (wait_cnt == WAIT_W'(SPLIT_THRESHOLD - 1));
  // Bit 0 is taken in IDLE, so the ADDR counter runs one behind the address index.
  assign addr_idx = (state == ADDR) ? (bit_cnt[3:0] + 4'd1) : 4'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    addr_bit_en  = 1'b0;
    wdata_bit_en = 1'b0;
    rdata_cap    = 1'b0;
    wait_inc     = 1'b0;
    split_set    = 1'b0;
    tx_load      = 1'b0;
    tx_load_data = rdata_q;
    case (state)
      IDLE: begin
        if (bus_sel && bus_data_in_valid && (bus_mode == MODE_ADDR)) begin
          addr_bit_en = 1'b1;
          state_nxt   = ADDR;
        end
      end
      ADDR: begin
        if (!bus_sel) begin
          state_nxt = IDLE;
        end else if (bus_data_in_valid) begin
          if (bus_mode != MODE_ADDR) begin
            state_nxt = IDLE;
          end else begin
            addr_bit_en = 1'b1;
            if (bit_cnt == 5'(BUS_ADDR_W - 2)) state_nxt = bus_rw ? WDATA : RD_REQ;
          end
        end
      end
      WDATA: begin
        if (!bus_sel) begin
          state_nxt = IDLE;
        end else if (bus_data_in_valid) begin
          if (bus_mode != MODE_DATA) begin
            state_nxt = IDLE;
          end else begin
            wdata_bit_en = 1'b1;
            if (bit_cnt == 5'(BUS_DATA_W - 1)) state_nxt = WR_REQ;
          end
        end
      end
      WR_REQ: begin
        if (mem_ready) state_nxt = ACK;
      end
      RD_REQ: begin
        if (mem_ready) state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        // Data arriving on the threshold cycle takes priority over splitting.
        if (mem_rvalid) begin
          rdata_cap    = 1'b1;
          tx_load      = 1'b1;
          tx_load_data = mem_rdata;
          state_nxt    = RD_OUT;
        end else if (SPLIT_EN && wait_hit) begin
          split_set = 1'b1;
          state_nxt = SPLIT;
        end else begin
          wait_inc = 1'b1;
        end
      end
      SPLIT: begin
        if (mem_rvalid && !have_data) rdata_cap = 1'b1;
        if ((have_data || mem_rvalid) && split_grant) begin
          tx_load      = 1'b1;
          tx_load_data = have_data ? rdata_q : mem_rdata;
          state_nxt    = RD_OUT;
        end
      end
      RD_OUT: begin
        if (bit_cnt == 5'(BUS_DATA_W - 1)) state_nxt = ACK;
      end
      ACK: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      wait_cnt  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      have_data <= 1'b0;
      split_q   <= 1'b0;
    end else begin
      if (state_nxt != state)
        bit_cnt <= '0;
      else if (addr_bit_en || wdata_bit_en || (state == RD_OUT))
        bit_cnt <= bit_cnt + 5'd1;

      if (state != RD_WAIT) wait_cnt <= '0;
      else if (wait_inc)    wait_cnt <= wait_cnt + 1'b1;

      // Only the locally decoded address bits are kept; upper bits are routed externally.
      if (addr_bit_en) begin
        for (int i = 0; i < MEM_ADDR_WIDTH; i++) begin
          if (addr_idx == 4'(i)) addr_q[i] <= bus_data_in;
        end
      end

      if (wdata_bit_en) wdata_q[bit_cnt[2:0]] <= bus_data_in;
      if (rdata_cap)    rdata_q <= mem_rdata;

      have_data <= (state_nxt == SPLIT) && (have_data || rdata_cap);
      split_q   <= split_set;
    end
  end

  serial_tx #(
    .WIDTH(BUS_DATA_W)
  ) u_serial_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tx_load),
    .load_data(tx_load_data),
    .shift    (state == RD_OUT),
    .data_out (bus_data_out),
    .valid    (bus_data_out_valid)
  );

  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_wen      = (state == WR_REQ);
  assign mem_ren      = (state == RD_REQ);
  assign target_ack   = (state == ACK);
  assign target_split = split_q;
  assign split_req    = (state == SPLIT);

endmodule

// File: doc/target_port.md
# target_port

Slave-side serial bus endpoint, the downstream counterpart of the initiator port. It deserialises the LSB-first 16-bit address and 8-bit write data from the serial bus and issues single-beat accesses to a local memory. For reads it waits for the memory data and serialises it back, using a split handshake when the memory is slow. It returns `target_ack` and `target_split` to the initiator side.

## Interface
Parameters:
- `MEM_ADDR_WIDTH`, default 12: local memory address bits, taken from the low bits of the bus address.
- `SPLIT_EN`, default 1: 1 enables split on slow reads.
- `SPLIT_THRESHOLD`, default 4: cycles to wait after read accept before splitting. Must be ≥1.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `bus_sel`  in  1  address decoder select for this target
- `bus_data_in`  in  1  serial bit from the initiator
- `bus_data_in_valid`  in  1  serial bit qualifier
- `bus_mode`  in  1  0 = address phase, 1 = data phase
- `bus_rw`  in  1  1 = write, 0 = read; sampled on the last address bit
- `bus_data_out`  out  1  serial read-data bit
- `bus_data_out_valid`  out  1  read-data bit qualifier
- `target_ack`  out  1  one-cycle completion pulse
- `target_split`  out  1  one-cycle split notification pulse
- `split_req`  out  1  request to the arbiter to resume a split read
- `split_grant`  in  1  arbiter grant for the resume
- `mem_addr`  out  `MEM_ADDR_WIDTH`  local address
- `mem_wdata`  out  8  write data
- `mem_wen`  out  1  write request; held until accepted
- `mem_ren`  out  1  read request; held until accepted
- `mem_ready`  in  1  accepts `mem_wen`/`mem_ren` in the same cycle
- `mem_rdata`  in  8  read data
- `mem_rvalid`  in  1  `mem_rdata` qualifier, one-cycle pulse

## Operation
- States:
  - `IDLE`: wait for bus_sel & bus_data_in_valid & bus_mode=0; captures bit 0; go to `ADDR`.
  - `ADDR`: one bit per valid cycle, LSB first. The 16th bit latches bus_rw and selects the next state: `WDATA` if 1, `RD_REQ` if 0.
  - `WDATA`: 8 bits with bus_mode=1, LSB first; go to `WR_REQ`.
  - `WR_REQ`: mem_wen=1 until mem_ready; go to `ACK`.
  - `RD_REQ`: mem_ren=1 until mem_ready; go to `RD_WAIT` and clear the wait counter.
  - `RD_WAIT`: counter increments each cycle without mem_rvalid.
    - mem_rvalid → capture mem_rdata; go to `RD_OUT`.
    - SPLIT_EN and counter reaches SPLIT_THRESHOLD → pulse target_split; go to `SPLIT`.
  - `SPLIT`: split_req=1. Capture mem_rdata on mem_rvalid. Once data is captured and split_grant=1, go to `RD_OUT`.
  - `RD_OUT`: 8 cycles with bus_data_out_valid=1, bus_data_out=rdata[i] for i=0..7; go to `ACK`.
  - `ACK`: target_ack=1 for one cycle; go to `IDLE`.
- Address and data counts use a 5-bit bit counter, cleared on every state entry.
- mem_addr = addr[MEM_ADDR_WIDTH-1:0]. Upper address bits are ignored; decoding is external.
- Abort to `IDLE`, with no memory access and no ack:
  - bus_sel drops in `ADDR` or `WDATA`.
  - A valid bit arrives with the wrong bus_mode for the phase.
- Serial input in all other states is ignored.
- If mem_rvalid and the threshold hit fall in the same cycle, the data wins: no split.
- If split_grant is already high when data is captured in `SPLIT`, `RD_OUT` starts the next cycle.

## Timing
- Reset values: all outputs 0, state `IDLE`, counters 0, data registers 0.
- Reset mid-operation aborts immediately. No ack or split is issued afterwards.
- mem_wen/mem_ren assert the cycle after the last serial bit is sampled.
- Write: target_ack is asserted the cycle after mem_ready is seen.
- Read, no split: the first bus_data_out_valid is the cycle after mem_rvalid.
- target_ack is asserted the cycle after the 8th read bit.
- Gaps in bus_data_in_valid stall capture without losing bits.

## Structure
- Shared package `bus_pkg`:
  - `BUS_ADDR_W`=16 and `BUS_DATA_W`=8.
  - Mode constants `MODE_ADDR`/`MODE_DATA`.
  - `target_state_e` enum.
- One natural sub-module: `serial_tx`, an 8-bit PISO. It has load, shift and valid, and drives bus_data_out/bus_data_out_valid. The initiator side can reuse it.

## Test plan
- Write 16'hA55A / 8'h3C, mem_ready tied 1 → one mem_wen cycle with mem_addr=12'h55A, mem_wdata=8'h3C; one target_ack pulse.
- Read 16'h1357, mem_rvalid 2 cycles after accept with 8'h96 → bus bits 0,1,1,0,1,0,0,1; then one target_ack; no target_split.
- Read with SPLIT_THRESHOLD=4, mem_rvalid after 10 cycles (8'h5A), split_grant 3 cycles after that → one target_split pulse; split_req high until `RD_OUT`; 8'h5A serialised; then ack.
- mem_ready low for 3 cycles on a write → mem_wen held 4 cycles; ack exactly once.
- bus_sel dropped after 7 address bits, then a full write to 16'h0001 / 8'hFF → first transfer produces no memory access; second completes normally.
- rst_n asserted during `RD_OUT` bit 3 → all outputs 0 immediately; no ack after release; next read works.
